// File: rtl/vector_pkg.sv
// Shared types and width helpers for the vector stream blocks.
// Packages cannot see module parameters, so every helper takes the
// lane count / widths as arguments and is evaluated at elaboration.
package vector_pkg;

   // Upper bound on lanes per beat supported by the keep helpers.
   localparam int MAX_LANES = 64;

   // ACCUM: result register empty; FULL: result register holds an unconsumed sum.
   typedef enum logic {
      ACCUM = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Width of the keep field: at least one bit even for a single lane.
   function automatic int keep_width_f(input int numbers);
      return (numbers > 1) ? $clog2(numbers) : 1;
   endfunction

   // Accumulator width: element width plus growth for a full vector plus sign headroom.
   function automatic int acc_width_f(input int number_width, input int vector_length);
      return number_width + $clog2(vector_length) + 1;
   endfunction

   // Number of valid lanes on a last beat; keep == 0 means every lane.
   function automatic int keep_to_count(input int keep, input int numbers);
      return (keep == 0) ? numbers : keep;
   endfunction

   // Thermometer lane mask for a last beat: lanes below the keep count are valid.
   function automatic logic [MAX_LANES-1:0] keep_to_mask(input int keep, input int numbers);
      logic [MAX_LANES-1:0] mask;
      int                   cnt;
      mask = '0;
      cnt  = keep_to_count(keep, numbers);
      for (int i = 0; i < MAX_LANES; i++) begin
         mask[i] = (i < cnt);
      end
      return mask;
   endfunction

endpackage

// File: rtl/vector_lane_sum.sv
// Combinational masked adder across the lanes of one beat.
// Each lane is sign-extended to the accumulator width; masked lanes add zero.
module vector_lane_sum
   import vector_pkg::*;
#(
   parameter int NUMBERS      = 1,
   parameter int NUMBER_WIDTH = 32,
   parameter int ACC_WIDTH    = 38
) (
   input  logic [NUMBERS*NUMBER_WIDTH-1:0] data,
   input  logic [NUMBERS-1:0]              mask,
   output logic signed [ACC_WIDTH-1:0]     sum
);

   // Sum all unmasked lanes of the beat.
   always_comb begin
      logic [NUMBER_WIDTH-1:0] lane;
      // NOTE: blocking '=' is correct here: the running sum must be visible to
      // the next loop iteration within the same evaluation.
      sum  = '0;
      lane = '0;
      for (int i = 0; i < NUMBERS; i++) begin
         lane = data[i*NUMBER_WIDTH +: NUMBER_WIDTH];
         if (mask[i]) begin
            sum = sum + {{(ACC_WIDTH-NUMBER_WIDTH){lane[NUMBER_WIDTH-1]}}, lane};
         end
      end
   end

endmodule

// File: rtl/vector_reduce_sum.sv
// Reduces every element of a vector stream to one signed scalar.
// Accepts one beat per cycle; the one-entry result register is freed in the
// same cycle it is consumed, so back-to-back vectors run without bubbles.
module vector_reduce_sum
   import vector_pkg::*;
#(
   parameter  int NUMBERS       = 1,
   parameter  int NUMBER_WIDTH  = 32,
   parameter  int VECTOR_LENGTH = 32,
   localparam int DATA_WIDTH    = NUMBER_WIDTH * NUMBERS,
   localparam int IDXW          = $clog2(VECTOR_LENGTH),
   localparam int INDEX_WIDTH   = IDXW * NUMBERS,
   localparam int KEEP_WIDTH    = keep_width_f(NUMBERS),
   localparam int ACC_WIDTH     = acc_width_f(NUMBER_WIDTH, VECTOR_LENGTH),
   localparam int CNTW          = IDXW + 1
) (
   input  logic                        clk,
   input  logic                        res_n,
   output logic                        x_ready,
   input  logic                        x_valid,
   input  logic [DATA_WIDTH-1:0]       x_data,
   input  logic [INDEX_WIDTH-1:0]      x_index,
   input  logic                        x_last,
   input  logic [KEEP_WIDTH-1:0]       x_keep,
   input  logic                        result_ready,
   output logic                        result_valid,
   output logic signed [ACC_WIDTH-1:0] result_data,
   output logic [CNTW-1:0]             result_count,
   output logic                        err
);

   state_t                      state;
   state_t                      state_next;
   logic                        accept;
   logic [NUMBERS-1:0]          lane_mask;
   logic signed [ACC_WIDTH-1:0] lane_sum;
   logic signed [ACC_WIDTH-1:0] acc;
   logic [CNTW-1:0]             elem_cnt;
   logic [31:0]                 lanes_in;
   logic [31:0]                 cnt_sum;
   logic                        overrun;
   logic                        idx_err;

   // The result slot can take a new sum when empty or when it is drained this cycle.
   assign x_ready      = res_n && ((state == ACCUM) || result_ready);
   assign accept       = x_valid && x_ready;
   assign result_valid = (state == FULL);

   // Lane masking only applies to the last beat; earlier beats are always full.
   assign lane_mask = x_last ? NUMBERS'(keep_to_mask(int'(x_keep), NUMBERS)) : '1;
   assign lanes_in  = x_last ? 32'(keep_to_count(int'(x_keep), NUMBERS)) : 32'(NUMBERS);
   assign cnt_sum   = 32'(elem_cnt) + lanes_in;
   assign overrun   = cnt_sum > 32'(VECTOR_LENGTH);
   assign idx_err   = CNTW'(x_index[IDXW-1:0]) != elem_cnt;

   vector_lane_sum #(
      .NUMBERS      (NUMBERS),
      .NUMBER_WIDTH (NUMBER_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH)
   ) u_lane_sum (
      .data (x_data),
      .mask (lane_mask),
      .sum  (lane_sum)
   );

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking '<=' for every register so all flops update from
      // pre-edge values regardless of process evaluation order.
      if (!res_n) state <= ACCUM;
      else        state <= state_next;
   end

   // Next state: a last beat fills the slot; a drain without refill empties it.
   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      case (state)
         ACCUM:   if (accept && x_last) state_next = FULL;
         FULL:    if (result_ready && !(accept && x_last)) state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   // Accumulator, element counter, result register and sticky error flag.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         acc          <= '0;
         elem_cnt     <= '0;
         result_data  <= '0;
         result_count <= '0;
         err          <= 1'b0;
      end else if (accept) begin
         if (idx_err || overrun) err <= 1'b1;
         if (x_last) begin
            result_data  <= acc + lane_sum;
            result_count <= CNTW'(cnt_sum);
            acc          <= '0;
            elem_cnt     <= '0;
         end else begin
            acc      <= acc + lane_sum;
            elem_cnt <= overrun ? CNTW'(VECTOR_LENGTH) : CNTW'(cnt_sum);
         end
      end
   end

endmodule

// File: tb/tb_vector_reduce_sum.sv
// Scoreboard bench: drivers push expected sums, per-DUT monitors pop and
// compare whenever a result is handed off. One DUT with 1 lane, one with 4.
module tb_vector_reduce_sum;

   localparam int ACCW = 38;
   localparam int CNTW = 6;

   typedef struct {
      longint data;
      int     count;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic res_n;

   // Single-lane DUT signals.
   logic                   a_x_ready, a_x_valid, a_x_last, a_x_keep;
   logic [31:0]            a_x_data;
   logic [4:0]             a_x_index;
   logic                   a_rr, a_rv, a_err;
   logic signed [ACCW-1:0] a_rd;
   logic [CNTW-1:0]        a_rc;
   logic                   rr_dir, rr_rand, rand_mode;

   // Four-lane DUT signals.
   logic                   b_x_ready, b_x_valid, b_x_last;
   logic [1:0]             b_x_keep;
   logic [127:0]           b_x_data;
   logic [19:0]            b_x_index;
   logic                   b_rr, b_rv, b_err;
   logic signed [ACCW-1:0] b_rd;
   logic [CNTW-1:0]        b_rc;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   pushed_a = 0;
   int   got_a    = 0;

   assign a_rr = rand_mode ? rr_rand : rr_dir;

   vector_reduce_sum #(.NUMBERS(1), .NUMBER_WIDTH(32), .VECTOR_LENGTH(32)) u_dut_a (
      .clk          (clk),
      .res_n        (res_n),
      .x_ready      (a_x_ready),
      .x_valid      (a_x_valid),
      .x_data       (a_x_data),
      .x_index      (a_x_index),
      .x_last       (a_x_last),
      .x_keep       (a_x_keep),
      .result_ready (a_rr),
      .result_valid (a_rv),
      .result_data  (a_rd),
      .result_count (a_rc),
      .err          (a_err)
   );

   vector_reduce_sum #(.NUMBERS(4), .NUMBER_WIDTH(32), .VECTOR_LENGTH(32)) u_dut_b (
      .clk          (clk),
      .res_n        (res_n),
      .x_ready      (b_x_ready),
      .x_valid      (b_x_valid),
      .x_data       (b_x_data),
      .x_index      (b_x_index),
      .x_last       (b_x_last),
      .x_keep       (b_x_keep),
      .result_ready (b_rr),
      .result_valid (b_rv),
      .result_data  (b_rd),
      .result_count (b_rc),
      .err          (b_err)
   );

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Random result_ready pattern for the stall phase.
   always @(posedge clk) begin
      #1 rr_rand = 1'($urandom_range(0, 1));
   end

   // Monitor for the single-lane DUT.
   always @(negedge clk) begin
      if (res_n === 1'b1 && a_rv === 1'b1 && a_rr === 1'b1) begin
         if (q_a.size() == 0) begin
            bound_fail("a_unexpected_result");
         end else begin
            ea = q_a.pop_front();
            check("a_result_data", a_rd, ea.data);
            check("a_result_count", a_rc, ea.count);
            got_a++;
         end
      end
   end

   // Monitor for the four-lane DUT.
   always @(negedge clk) begin
      if (res_n === 1'b1 && b_rv === 1'b1 && b_rr === 1'b1) begin
         if (q_b.size() == 0) begin
            bound_fail("b_unexpected_result");
         end else begin
            eb = q_b.pop_front();
            check("b_result_data", b_rd, eb.data);
            check("b_result_count", b_rc, eb.count);
         end
      end
   end

   task automatic push_a(input longint data, input int count);
      exp_t e;
      e.data  = data;
      e.count = count;
      q_a.push_back(e);
      pushed_a++;
   endtask

   task automatic push_b(input longint data, input int count);
      exp_t e;
      e.data  = data;
      e.count = count;
      q_b.push_back(e);
   endtask

   // Entered and left just after a rising edge.
   task automatic send_a(input int data, input int idx, input bit last);
      a_x_valid = 1'b1;
      a_x_data  = 32'(data);
      a_x_index = 5'(idx);
      a_x_last  = last;
      a_x_keep  = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 200 && a_x_ready !== 1'b1; t++) @(negedge clk);
      if (a_x_ready !== 1'b1) bound_fail("a_x_ready_wait");
      @(posedge clk);
      #1 a_x_valid = 1'b0;
   endtask

   task automatic send_b(input int d0, input int d1, input int d2, input int d3,
                         input int idx, input bit last, input int keep);
      b_x_valid = 1'b1;
      b_x_data  = {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
      b_x_index = {5'(idx + 3), 5'(idx + 2), 5'(idx + 1), 5'(idx)};
      b_x_last  = last;
      b_x_keep  = 2'(keep);
      @(negedge clk);
      for (int t = 0; t < 200 && b_x_ready !== 1'b1; t++) @(negedge clk);
      if (b_x_ready !== 1'b1) bound_fail("b_x_ready_wait");
      @(posedge clk);
      #1 b_x_valid = 1'b0;
   endtask

   task automatic drain_all();
      for (int t = 0; t < 500 && (q_a.size() != 0 || q_b.size() != 0); t++) begin
         @(posedge clk);
         #1;
      end
      if (q_a.size() != 0 || q_b.size() != 0) bound_fail("drain");
   endtask

   // One-cycle reset pulse; x_ready must be low while reset is sampled.
   task automatic pulse_reset();
      res_n = 1'b0;
      @(negedge clk);
      check("a_x_ready_in_reset", a_x_ready, 0);
      check("b_x_ready_in_reset", b_x_ready, 0);
      @(posedge clk);
      #1 res_n = 1'b1;
   endtask

   initial begin
      int len;
      int vals[8];
      longint sum;

      res_n = 1'b0;
      rr_dir = 1'b1; rand_mode = 1'b0;
      a_x_valid = 1'b0; a_x_data = '0; a_x_index = '0; a_x_last = 1'b0; a_x_keep = 1'b0;
      b_x_valid = 1'b0; b_x_data = '0; b_x_index = '0; b_x_last = 1'b0; b_x_keep = '0;
      b_rr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      pulse_reset();
      check("reset_result_valid", a_rv, 0);
      check("reset_result_data", a_rd, 0);
      check("reset_result_count", a_rc, 0);
      check("reset_err", a_err, 0);
      check("b_reset_result_valid", b_rv, 0);

      // Full-length single-lane vector 1..32.
      for (int i = 1; i <= 32; i++) begin
         if (i == 32) push_a(528, 32);
         send_a(i, i - 1, i == 32);
         if (i == 31) check("t1_no_early_valid", a_rv, 0);
      end
      check("t1_valid_next_cycle", a_rv, 1);
      check("t1_err_clean", a_err, 0);
      drain_all();

      // Held result with back-pressure, then drain and refill in one cycle.
      rr_dir = 1'b0;
      push_a(10, 4);
      for (int i = 0; i < 4; i++) send_a(i + 1, i, i == 3);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t3_x_ready_low", a_x_ready, 0);
         check("t3_held_valid", a_rv, 1);
         check("t3_held_data", a_rd, 10);
      end
      @(posedge clk);
      #1 rr_dir = 1'b1;
      push_a(20, 1);
      send_a(20, 0, 1);
      check("t3_valid_stays", a_rv, 1);
      check("t3_b_loaded", a_rd, 20);
      drain_all();

      // Four-lane vectors with keep masking.
      push_b(-1, 6);
      send_b(1, 2, 3, 4, 0, 0, 0);
      send_b(-5, -6, 7, 8, 4, 1, 2);
      push_b(100, 4);
      send_b(10, 20, 30, 40, 0, 1, 0);
      push_b(-7, 1);
      send_b(-7, 99, 99, 99, 0, 1, 1);
      push_b(-9, 3);
      send_b(5, 6, -20, 1000, 0, 1, 3);
      push_b(32, 32);
      for (int i = 0; i < 8; i++) send_b(1, 1, 1, 1, 4 * i, i == 7, 0);
      drain_all();
      check("t2_b_err_clean", b_err, 0);

      // Index skip sets a sticky error.
      pulse_reset();
      send_a(1, 0, 0);
      send_a(1, 1, 0);
      check("t4_err_before_skip", a_err, 0);
      send_a(1, 3, 0);
      check("t4_err_after_skip", a_err, 1);
      push_a(4, 4);
      send_a(1, 4, 1);
      push_a(5, 1);
      send_a(5, 0, 1);
      drain_all();
      check("t4_err_sticky", a_err, 1);
      pulse_reset();
      check("t4_err_cleared", a_err, 0);

      // Reset mid-vector discards the partial sum.
      for (int i = 0; i < 5; i++) send_a(1, i, 0);
      pulse_reset();
      push_a(7, 1);
      send_a(7, 0, 1);
      drain_all();
      check("t5_err_clean", a_err, 0);

      // Random stalls on both sides against a bench-side sum model.
      rand_mode = 1'b1;
      for (int v = 0; v < 60; v++) begin
         len = $urandom_range(1, 8);
         sum = 0;
         for (int j = 0; j < len; j++) begin
            vals[j] = int'($urandom_range(0, 2000)) - 1000;
            sum += longint'(vals[j]);
         end
         push_a(sum, len);
         for (int j = 0; j < len; j++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            send_a(vals[j], j, j == len - 1);
         end
      end
      drain_all();
      rand_mode = 1'b0;
      check("t6_err_clean", a_err, 0);
      check("t6_no_loss_dup", got_a, pushed_a);

      // Four-lane length overrun.
      for (int i = 0; i < 8; i++) send_b(1, 1, 1, 1, 4 * i, 0, 0);
      check("overrun_err_before", b_err, 0);
      send_b(1, 1, 1, 1, 0, 0, 0);
      check("overrun_err_after", b_err, 1);
      pulse_reset();
      check("overrun_err_cleared", b_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
